program_sequencer: RTL and testbench
====================================

Name: program_sequencer

Overview:
Upstream neighbour of the 4-bit computational unit. It generates the 8-bit program memory address each cycle and resolves unconditional jumps, conditional jumps on the CU zero flag, and subroutine call/return through a small hardware return stack. It drives sub_flag, which the computational unit uses to select its alternate x0/y0/o_reg bank. Program memory is asynchronous-read, so the instruction at pm_addr is decoded, and its strobes arrive, in the same cycle.

Parameters:
ADDR_W, 8, program address width in bits; the jump target is {jmp_nibble, (ADDR_W-4) zeros}
STACK_DEPTH, 4, number of return-address entries; must be a power of 2, minimum 2

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset_n  input  1  asynchronous active-low reset
hold  input  1  freezes all sequencer state this cycle
jump  input  1  unconditional jump strobe from the decoder
conditional_jump  input  1  jump-if-not-zero strobe from the decoder
call  input  1  subroutine call strobe
ret  input  1  subroutine return strobe
jmp_nibble  input  4  target high nibble, taken from the instruction operand
r_eq_0  input  1  zero flag from the computational unit
pm_addr  output  ADDR_W  registered program memory address; the current instruction's address
sub_flag  output  1  1 while at least one return address is stacked
depth  output  clog2(STACK_DEPTH)+1  number of valid stack entries
stack_ovf  output  1  sticky: a call was attempted while the stack was full
stack_unf  output  1  sticky: a ret was attempted while the stack was empty

Behaviour:
- Reset (reset_n=0, asynchronous) sets pm_addr=0, depth=0, sub_flag=0, stack_ovf=0 and stack_unf=0. Stack contents become don't-care. Release is synchronised to clk.
- Define target = {jmp_nibble, zeros} and inc = pm_addr+1, computed modulo 2^ADDR_W (0xFF wraps to 0x00).
- Every cycle the next pm_addr is selected by strict priority:
  1. hold=1: pm_addr, depth and the flags all hold. Every strobe is ignored.
  2. ret=1 and depth>0: pm_addr <= top of stack (pop), depth-1.
  3. ret=1 and depth=0: stack_unf <= 1, pm_addr <= inc.
  4. call=1 and depth<STACK_DEPTH: push inc, pm_addr <= target, depth+1.
  5. call=1 and depth=STACK_DEPTH: stack_ovf <= 1, pm_addr <= inc, no push.
  6. jump=1: pm_addr <= target.
  7. conditional_jump=1 and r_eq_0=0: pm_addr <= target.
  8. Otherwise, including conditional_jump with r_eq_0=1: pm_addr <= inc.
- Simultaneous strobes resolve by the priority above. The losing strobes have no side effects.
- Latency: the new address appears on pm_addr one clk after the strobe cycle. There are no delay slots.
- The stack is a LIFO register file with a pointer. A push writes at index depth and a pop reads index depth-1. A push and a pop never occur in the same cycle.
- sub_flag is registered and equals (depth!=0) after every edge. It must change in the same cycle as depth, so the CU bank switch takes effect on the first subroutine instruction and on the first instruction after the return.
- stack_ovf and stack_unf are cleared only by reset.
- r_eq_0 is sampled only in a cycle where conditional_jump wins priority.
- Reset asserted mid-subroutine abandons the stack immediately (depth=0, sub_flag=0). Execution restarts at address 0.

Test Plan:
- Reset then free-run 260 cycles with no strobes -> pm_addr runs 0x00..0xFF, then 0x00, 0x01, 0x02, 0x03. sub_flag=0 throughout.
- At pm_addr=0x12: conditional_jump=1, jmp_nibble=0x7, r_eq_0=0 -> pm_addr=0x70. Repeat with r_eq_0=1 -> pm_addr=0x13.
- At pm_addr=0x21: call=1, jmp_nibble=0x5 -> pm_addr=0x50, depth=1, sub_flag=1. Three cycles later (pm_addr=0x53) ret=1 -> pm_addr=0x22, depth=0, sub_flag=0.
- Nest four calls (targets 0x10, 0x20, 0x30, 0x40), then a fifth call -> stack_ovf=1, pm_addr=0x41, depth=4. Four rets then return in LIFO order to each call address+1. A fifth ret -> stack_unf=1 and pm_addr increments.
- At pm_addr=0x30 with ret=1, call=1 and jump=1 together and depth=1 (top=0x88) -> pm_addr=0x88, depth=0. With hold=1 and the same strobes instead -> pm_addr stays 0x30 and depth stays 1.
- At depth=2 and pm_addr=0x44, drive reset_n low mid-cycle -> pm_addr=0, depth=0, sub_flag=0 and both flags 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/program_sequencer.sv
// Program sequencer: drives the program memory address, resolves jumps and
// subroutine call/return through a small LIFO return stack.
module program_sequencer #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         hold,
   input  logic                         jump,
   input  logic                         conditional_jump,
   input  logic                         call,
   input  logic                         ret,
   input  logic [3:0]                   jmp_nibble,
   input  logic                         r_eq_0,
   output logic [ADDR_W-1:0]            pm_addr,
   output logic                         sub_flag,
   output logic [$clog2(STACK_DEPTH):0] depth,
   output logic                         stack_ovf,
   output logic                         stack_unf
);

   localparam int PW = $clog2(STACK_DEPTH);
   localparam int DW = PW + 1;

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_POP,
      ACT_UNF,
      ACT_PUSH,
      ACT_OVF,
      ACT_JUMP,
      ACT_INC
   } act_t;

   act_t              act;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] inc;
   logic [ADDR_W-1:0] top;
   logic [ADDR_W-1:0] pm_addr_nxt;
   logic [DW-1:0]     depth_nxt;
   logic              ovf_nxt;
   logic              unf_nxt;
   logic              full;
   logic              empty;
   logic [PW-1:0]     push_idx;
   logic [PW-1:0]     pop_idx;
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

   assign target   = {jmp_nibble, {(ADDR_W-4){1'b0}}};
   assign inc      = pm_addr + 1'b1;
   assign empty    = (depth == '0);
   assign full     = (depth == DW'(STACK_DEPTH));
   assign push_idx = depth[PW-1:0];
   assign pop_idx  = push_idx - 1'b1;
   assign top      = stack_mem[pop_idx];

   // Strict priority; the winning action alone produces side effects.
   always_comb begin
      act = ACT_INC;
      if (hold)
         act = ACT_HOLD;
      else if (ret)
         act = empty ? ACT_UNF : ACT_POP;
      else if (call)
         act = full ? ACT_OVF : ACT_PUSH;
      else if (jump || (conditional_jump && !r_eq_0))
         act = ACT_JUMP;
   end

   always_comb begin
      pm_addr_nxt = pm_addr;
      depth_nxt   = depth;
      ovf_nxt     = stack_ovf;
      unf_nxt     = stack_unf;
      case (act)
         ACT_HOLD: ;
         ACT_POP: begin
            pm_addr_nxt = top;
            depth_nxt   = depth - 1'b1;
         end
         ACT_UNF: begin
            pm_addr_nxt = inc;
            unf_nxt     = 1'b1;
         end
         ACT_PUSH: begin
            pm_addr_nxt = target;
            depth_nxt   = depth + 1'b1;
         end
         ACT_OVF: begin
            pm_addr_nxt = inc;
            ovf_nxt     = 1'b1;
         end
         ACT_JUMP: pm_addr_nxt = target;
         ACT_INC:  pm_addr_nxt = inc;
         default:  ;
      endcase
   end

   // sub_flag tracks the next depth so the bank switch lands with the new address.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pm_addr   <= '0;
         depth     <= '0;
         sub_flag  <= 1'b0;
         stack_ovf <= 1'b0;
         stack_unf <= 1'b0;
      end else begin
         pm_addr   <= pm_addr_nxt;
         depth     <= depth_nxt;
         sub_flag  <= (depth_nxt != '0);
         stack_ovf <= ovf_nxt;
         stack_unf <= unf_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (act == ACT_PUSH)
         stack_mem[push_idx] <= inc;
   end

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: a queue-based reference model pushes
// expected state per cycle; a monitor pops and compares after each edge.
module tb_program_sequencer;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       hold = 1'b0;
   logic       jump = 1'b0;
   logic       conditional_jump = 1'b0;
   logic       call = 1'b0;
   logic       ret = 1'b0;
   logic [3:0] jmp_nibble = 4'h0;
   logic       r_eq_0 = 1'b0;
   logic [7:0] pm_addr;
   logic       sub_flag;
   logic [2:0] depth;
   logic       stack_ovf;
   logic       stack_unf;

   program_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .hold(hold), .jump(jump),
      .conditional_jump(conditional_jump), .call(call), .ret(ret),
      .jmp_nibble(jmp_nibble), .r_eq_0(r_eq_0), .pm_addr(pm_addr),
      .sub_flag(sub_flag), .depth(depth), .stack_ovf(stack_ovf),
      .stack_unf(stack_unf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pc;
      logic [2:0] dep;
      logic       sub;
      logic       ovf;
      logic       unf;
      string      tag;
   } exp_t;

   exp_t       sb[$];
   event       async_chk;
   int         n_cmp = 0;
   int         n_fail = 0;

   logic [7:0] m_pc = 8'h00;
   logic [7:0] m_stack[$];
   logic       m_ovf = 1'b0;
   logic       m_unf = 1'b0;

   task automatic push_exp(input string tag);
      exp_t e;
      e.pc  = m_pc;
      e.dep = 3'(m_stack.size());
      e.sub = (m_stack.size() != 0);
      e.ovf = m_ovf;
      e.unf = m_unf;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic model_reset();
      m_pc = 8'h00;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Drive one cycle's strobes now and record the state expected after the next edge.
   task automatic step_now(input logic h, input logic j, input logic cj, input logic c,
                           input logic r, input logic [3:0] nib, input logic z,
                           input string tag);
      logic [7:0] tgt;
      hold = h; jump = j; conditional_jump = cj; call = c; ret = r;
      jmp_nibble = nib; r_eq_0 = z;
      tgt = {nib, 4'h0};
      if (h) begin
      end else if (r && m_stack.size() > 0) begin
         m_pc = m_stack.pop_back();
      end else if (r) begin
         m_unf = 1'b1;
         m_pc = m_pc + 8'd1;
      end else if (c && m_stack.size() < 4) begin
         m_stack.push_back(m_pc + 8'd1);
         m_pc = tgt;
      end else if (c) begin
         m_ovf = 1'b1;
         m_pc = m_pc + 8'd1;
      end else if (j || (cj && !z)) begin
         m_pc = tgt;
      end else begin
         m_pc = m_pc + 8'd1;
      end
      push_exp(tag);
   endtask

   task automatic step(input logic h, input logic j, input logic cj, input logic c,
                       input logic r, input logic [3:0] nib, input logic z,
                       input string tag);
      @(negedge clk);
      step_now(h, j, cj, c, r, nib, z, tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, tag);
   endtask

   task automatic run_to(input logic [7:0] addr);
      int guard = 0;
      while (m_pc != addr && guard < 300) begin
         idle("run");
         guard++;
      end
      if (m_pc != addr) begin
         n_cmp++;
         n_fail++;
         $display("FAIL run_to: model pc=%h never reached %h", m_pc, addr);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk or async_chk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp++;
            if (pm_addr !== e.pc || depth !== e.dep || sub_flag !== e.sub ||
                stack_ovf !== e.ovf || stack_unf !== e.unf) begin
               n_fail++;
               $display("FAIL %s: got pc=%h depth=%0d sub=%b ovf=%b unf=%b, expected pc=%h depth=%0d sub=%b ovf=%b unf=%b",
                        e.tag, pm_addr, depth, sub_flag, stack_ovf, stack_unf,
                        e.pc, e.dep, e.sub, e.ovf, e.unf);
            end
         end
      end
   end

   initial begin : stimulus
      #1 reset_n = 1'b0;
      model_reset();
      push_exp("reset");
      #2 -> async_chk;

      @(negedge clk);
      reset_n = 1'b1;
      step_now(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "freerun");
      for (int i = 1; i < 260; i++) idle("freerun");

      run_to(8'h12);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 1'b0, "cjump_taken");
      run_to(8'h12);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, "cjump_not_taken");

      run_to(8'h21);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 1'b0, "call");
      for (int i = 0; i < 3; i++) idle("in_sub");
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "ret");

      for (int k = 1; k <= 5; k++)
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'(k), 1'b0, k == 5 ? "call_ovf" : "nest_call");
      for (int k = 1; k <= 5; k++)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, k == 5 ? "ret_unf" : "nest_ret");

      run_to(8'h87);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h3, 1'b0, "call_to_30");
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, "hold_all_strobes");
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, "ret_beats_call_jump");

      for (int i = 0; i < 400; i++)
         step($urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(3) == 0,
              $urandom_range(5) == 0, $urandom_range(5) == 0, 4'($urandom_range(15)),
              1'($urandom_range(1)), "random");

      while (m_stack.size() > 0)
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0, "drain");
      run_to(8'h10);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 1'b0, "pre_reset_call");
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h4, 1'b0, "pre_reset_call");
      run_to(8'h44);
      @(posedge clk);
      #3 reset_n = 1'b0;
      hold = 1'b0; jump = 1'b0; conditional_jump = 1'b0; call = 1'b0; ret = 1'b0;
      model_reset();
      push_exp("async_reset_mid_sub");
      #1 -> async_chk;

      @(negedge clk);
      reset_n = 1'b1;
      step_now(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, "after_reset");
      for (int i = 0; i < 4; i++) idle("after_reset");

      @(posedge clk);
      #3;
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
